// File: rtl/controlador_memoria_4x8_pkg.sv
// Shared types and sizing for the 4x8 word memory controller.
// Holds the FSM state enumeration and the default geometry.
package controlador_memoria_4x8_pkg;

    localparam int ADDR_W_DEF  = 2;
    localparam int N_WORDS_DEF = 4;
    localparam int WORD_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READ   = 3'd3,
        ST_RESP   = 3'd4
    } estado_t;

endpackage

// File: rtl/controlador_memoria_4x8_decodificador_onehot.sv
// One-hot word-select decoder: bit i set when en=1 and addr=i.
// All bits are zero when en=0.
module decodificador_onehot #(
    parameter int ADDR_W  = 2,
    parameter int N_WORDS = 4
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic               en,
    output logic [N_WORDS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (en && (addr == i[ADDR_W-1:0])) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_memoria_4x8.sv
// Single-request controller for N_WORDS parallel 8-bit words: one-hot write
// strobe with settle cycle, registered read with valid/ready response.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready=1
// WRITE  | one-cycle ram_we pulse for the captured address
// SETTLE | ram_we released, ram_wdata held
// READ   | two cycles; selected word registered on the second
// RESP   | rsp_valid=1 until rsp_ready
module controlador_memoria_4x8
    import controlador_memoria_4x8_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int N_WORDS = N_WORDS_DEF
) (
    input  logic                        clk,
    input  logic                        preset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [WORD_W-1:0]           req_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WORD_W-1:0]           rsp_data,
    output logic [N_WORDS-1:0]          ram_we,
    output logic [WORD_W-1:0]           ram_wdata,
    input  logic [WORD_W*N_WORDS-1:0]   ram_rdata,
    output logic                        busy
);

    estado_t             estado, estado_sig;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                fase_lectura;
    logic                aceptar;
    logic                we_en;
    logic [WORD_W-1:0]   palabra_sel;

    assign aceptar = req_valid && (estado == ST_IDLE);

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            estado <= ST_IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ST_IDLE:   if (req_valid) estado_sig = req_write ? ST_WRITE : ST_READ;
            ST_WRITE:  estado_sig = ST_SETTLE;
            ST_SETTLE: estado_sig = ST_IDLE;
            ST_READ:   if (fase_lectura) estado_sig = ST_RESP;
            ST_RESP:   if (rsp_ready) estado_sig = ST_IDLE;
            default:   estado_sig = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (estado == ST_IDLE);
        busy      = (estado != ST_IDLE);
        rsp_valid = (estado == ST_RESP);
        we_en     = (estado == ST_WRITE);
    end

    always_comb begin
        palabra_sel = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (addr_q == i[ADDR_W-1:0]) begin
                palabra_sel = ram_rdata[i*WORD_W +: WORD_W];
            end
        end
    end

    // READ spans two cycles so a read response lands at the same
    // turnaround after accept as a write's return to IDLE.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_data     <= '0;
            fase_lectura <= 1'b0;
        end else begin
            if (aceptar) begin
                addr_q  <= req_addr;
                wdata_q <= req_data;
            end
            fase_lectura <= (estado == ST_READ) && !fase_lectura;
            if ((estado == ST_READ) && fase_lectura) begin
                rsp_data <= palabra_sel;
            end
        end
    end

    assign ram_wdata = wdata_q;

    decodificador_onehot #(
        .ADDR_W  (ADDR_W),
        .N_WORDS (N_WORDS)
    ) u_decodificador (
        .addr   (addr_q),
        .en     (we_en),
        .onehot (ram_we)
    );

endmodule

// File: tb/tb_controlador_memoria_4x8.sv
// Bench for controlador_memoria_4x8: transaction-latency model checked every
// cycle, a small RAM model on the ram_* port, and directed literal checks.
module tb_controlador_memoria_4x8;

    logic        clk = 1'b0;
    logic        preset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_data;
    logic [3:0]  ram_we;
    logic [7:0]  ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    controlador_memoria_4x8 dut (
        .clk       (clk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: four words, written by ram_we, preloadable by the bench
    logic [7:0]  mem [4];
    logic        preload = 1'b0;
    logic [31:0] preload_val = '0;
    assign ram_rdata = {mem[3], mem[2], mem[1], mem[0]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4; i++) mem[i] <= preload_val[i*8 +: 8];
        end else begin
            for (int i = 0; i < 4; i++) if (ram_we[i]) mem[i] <= ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request keeps the block busy two cycles; a write
    // strobes on the first, a read then presents the word until rsp_ready.
    int         m_wait = 0;
    bit         m_resp = 1'b0;
    bit         m_write = 1'b0;
    logic [1:0] m_addr = '0;
    logic [7:0] m_wdata = '0;
    logic [7:0] m_rdata = '0;
    logic [7:0] m_pending = '0;

    always @(posedge clk or posedge preset) begin
        if (preset) begin
            m_wait  <= 0;
            m_resp  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp <= 1'b0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1 && !m_write) begin
                m_resp  <= 1'b1;
                m_rdata <= m_pending;
            end
        end else if (req_valid) begin
            m_write   <= req_write;
            m_addr    <= req_addr;
            m_wdata   <= req_data;
            m_pending <= mem[req_addr];
            m_wait    <= 2;
        end
    end

    int cyc = 0;
    int pulse_total = 0;
    int last_pulse = -1;
    int min_gap = 1000;

    always @(negedge clk) begin
        logic       e_ready;
        logic [3:0] e_we;
        cyc <= cyc + 1;
        if (ram_we != 4'b0) begin
            pulse_total <= pulse_total + 1;
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap <= cyc - last_pulse;
            last_pulse <= cyc;
        end
        if (chk_en) begin
            e_ready = (m_wait == 0) && !m_resp;
            e_we    = (m_write && m_wait == 2) ? (4'b0001 << m_addr) : 4'b0000;
            chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
            chk("busy", {31'b0, busy}, {31'b0, !e_ready});
            chk("ram_we", {28'b0, ram_we}, {28'b0, e_we});
            chk("ram_wdata", {24'b0, ram_wdata}, {24'b0, m_wdata});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
            chk("rsp_data", {24'b0, rsp_data}, {24'b0, m_rdata});
            chk("ram_we_onehot", {31'b0, ($countones(ram_we) <= 1)}, 32'd1);
        end
    end

    // Issue one request; returns #1 after the accepting edge.
    task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int base;
        #2 preset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
        chk("rst_ram_we", {28'b0, ram_we}, 32'd0);
        chk("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
        preload_val = 32'h4433_2211;
        preload = 1'b1;
        tick();
        preload = 1'b0;
        chk_en = 1'b1;
        preset = 1'b0;
        tick();

        // write 0xAA to addr 2
        do_req(1'b1, 2'd2, 8'hAA);
        chk("wr_we", {28'b0, ram_we}, 32'h4);
        chk("wr_wdata", {24'b0, ram_wdata}, 32'hAA);
        chk("wr_ready0", {31'b0, req_ready}, 32'd0);
        tick();
        chk("wr_we_off", {28'b0, ram_we}, 32'h0);
        chk("wr_ready1", {31'b0, req_ready}, 32'd0);
        chk("wr_settle_wdata", {24'b0, ram_wdata}, 32'hAA);
        tick();
        chk("wr_ready_back", {31'b0, req_ready}, 32'd1);
        chk("wr_mem2", {24'b0, mem[2]}, 32'hAA);

        // restore word 2 and read addr 3
        do_req(1'b1, 2'd2, 8'h33);
        tick(); tick();
        do_req(1'b0, 2'd3, 8'h00);
        chk("rd_valid_t1", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("rd_valid_t2", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("rd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_data", {24'b0, rsp_data}, 32'h44);
        tick();

        // response stall for 5 cycles
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd1, 8'h00);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_data", {24'b0, rsp_data}, 32'h22);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("stall_release_valid", {31'b0, rsp_valid}, 32'd0);
        chk("stall_release_ready", {31'b0, req_ready}, 32'd1);

        // write then read same address
        do_req(1'b1, 2'd1, 8'h5A);
        do_req(1'b0, 2'd1, 8'h00);
        wait_rsp();
        chk("wr_rd_data", {24'b0, rsp_data}, 32'h5A);
        tick(); tick();

        // preset during WRITE
        do_req(1'b1, 2'd0, 8'h77);
        chk("abort_we_before", {28'b0, ram_we}, 32'h1);
        #2 preset = 1'b1;
        #1;
        chk("abort_we", {28'b0, ram_we}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        #3 preset = 1'b0;
        tick(); tick();
        chk("abort_mem0", {24'b0, mem[0]}, 32'h11);
        do_req(1'b1, 2'd3, 8'h99);
        chk("post_abort_we", {28'b0, ram_we}, 32'h8);
        do_req(1'b0, 2'd3, 8'h00);
        wait_rsp();
        chk("post_abort_rd", {24'b0, rsp_data}, 32'h99);
        tick(); tick();

        // req_valid held across three writes
        base = pulse_total;
        k = 0;
        req_write = 1'b1;
        req_addr  = 2'd2;
        req_data  = 8'h3C;
        req_valid = 1'b1;
        for (int i = 0; i < 30 && k < 3; i++) begin
            tick();
            if (ram_we != 4'b0) k++;
        end
        req_valid = 1'b0;
        repeat (8) tick();
        chk("held_pulses", pulse_total - base, 32'd3);
        chk("pulse_gap_ok", {31'b0, (min_gap >= 2)}, 32'd1);
        chk("held_mem2", {24'b0, mem[2]}, 32'h3C);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
